muldiv_unit: RTL and testbench

Iterative, parametrised multiply/divide unit implementing the full RV32M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits beside the single-cycle ALU in the execute stage. It accepts one operation through a start/ready handshake, stalls the pipeline while busy, and returns a registered result with a one-cycle done pulse. Width and bits-retired-per-cycle are parameters. Divide-by-zero and signed overflow complete on a one-cycle fast path.

---
 rtl/muldiv_unit.sv | 207 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide unit for the execute stage. One operation
//   is accepted through start/ready. The unit runs DATA_WIDTH/STEP BUSY cycles
//   and then raises done for one cycle with the result registered. Divide by
//   zero and signed divide overflow skip the iteration and finish directly.
//
// Handshake: an operation is accepted on a rising edge where
//   start & ready & ~kill. ready is high in IDLE and DONE, so a new operation
//   can be issued in the done cycle. busy stalls the pipeline. done is a
//   one-cycle pulse. result holds its value until the next done.
//   kill aborts any operation, gives no done, and leaves result unchanged.
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset
//   start   in   operation request
//   op      in   funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   in1     in   rs1 (multiplicand / dividend)
//   in2     in   rs2 (multiplier / divisor)
//   kill    in   pipeline flush
//   ready   out  unit can accept start
//   busy    out  iteration in progress
//   done    out  one-cycle result-valid pulse
//   result  out  registered result
// ---------------------------------------------------------------------------
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int STEP       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  input  logic                  kill,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W  = DATA_WIDTH;
  localparam int N  = DATA_WIDTH / STEP;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [W-1:0]   ONE_W  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [2*W-1:0] ONE_2W = {{(2*W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]   MIN_W  = {1'b1, {(W-1){1'b0}}};

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     op_q, op_d;
  logic           neg_q, neg_d;     // product / quotient sign
  logic           s1_q, s1_d;       // remainder sign
  logic [W-1:0]   b_q, b_d;         // multiplicand or divisor magnitude
  logic [2*W-1:0] acc_q, acc_d;     // {high, low} working register
  logic [W-1:0]   result_q, result_d;

  // Accept-side decode
  logic           accept;
  logic           sg1, sg2, s1, s2;
  logic [W-1:0]   mag1, mag2;
  logic           div_zero, div_ovf;
  logic [W-1:0]   fast_res;

  // Iteration datapath
  logic [2*W-1:0] acc_step;
  logic [W:0]     rem_sh;
  logic [W:0]     hi_sum;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quot, rmd;
  logic [W-1:0]   res_norm;

  assign ready  = (state_q != S_BUSY);
  assign busy   = (state_q == S_BUSY);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

  assign accept = start & ready & ~kill;

  // Signedness of each source: for divides op[0] selects unsigned, for
  // multiplies only MULHU treats rs1 as unsigned and MULHSU/MULHU rs2.
  assign sg1  = op[2] ? ~op[0] : (op[1:0] != 2'b11);
  assign sg2  = op[2] ? ~op[0] : ~op[1];
  assign s1   = sg1 & in1[W-1];
  assign s2   = sg2 & in2[W-1];
  assign mag1 = s1 ? (~in1 + ONE_W) : in1;
  assign mag2 = s2 ? (~in2 + ONE_W) : in2;

  assign div_zero = op[2] & (in2 == '0);
  assign div_ovf  = op[2] & ~op[0] & (in1 == MIN_W) & (in2 == '1);
  // op[1] distinguishes REM/REMU from DIV/DIVU.
  assign fast_res = div_zero ? (op[1] ? in1 : '1) : (op[1] ? '0 : in1);

  // STEP iterations per cycle. Multiply: shift-add with the multiplier in the
  // low half, consumed from the LSB. Divide: restoring division with the
  // dividend in the low half shifted into the remainder in the high half;
  // quotient bits enter the low half from the right.
  always_comb begin
    acc_step = acc_q;
    rem_sh   = '0;
    hi_sum   = '0;
    for (int i = 0; i < STEP; i++) begin
      if (op_q[2]) begin
        rem_sh = {acc_step[2*W-1:W], acc_step[W-1]};
        if (rem_sh >= {1'b0, b_q}) begin
          rem_sh   = rem_sh - {1'b0, b_q};
          acc_step = {rem_sh[W-1:0], acc_step[W-2:0], 1'b1};
        end else begin
          acc_step = {rem_sh[W-1:0], acc_step[W-2:0], 1'b0};
        end
      end else begin
        hi_sum   = {1'b0, acc_step[2*W-1:W]} + (acc_step[0] ? {1'b0, b_q} : '0);
        acc_step = {hi_sum, acc_step[W-1:1]};
      end
    end
  end

  // Final sign correction, applied only when result is written.
  always_comb begin
    prod_fix = neg_q ? (~acc_step + ONE_2W) : acc_step;
    quot     = acc_step[W-1:0];
    rmd      = acc_step[2*W-1:W];
    res_norm = '0;
    if (op_q[2]) begin
      if (op_q[1]) res_norm = s1_q ? (~rmd + ONE_W) : rmd;
      else         res_norm = neg_q ? (~quot + ONE_W) : quot;
    end else begin
      res_norm = (op_q[1:0] == 2'b00) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    s1_d     = s1_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;

    case (state_q)
      S_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        acc_d = acc_step;
        if (cnt_q == CW'(1)) begin
          state_d  = S_DONE;
          result_d = res_norm;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      op_d  = op;
      neg_d = s1 ^ s2;
      s1_d  = s1;
      if (div_zero | div_ovf) begin
        state_d  = S_DONE;
        cnt_d    = '0;
        result_d = fast_res;
      end else begin
        state_d = S_BUSY;
        cnt_d   = CW'(N);
        acc_d   = {{W{1'b0}}, (op[2] ? mag1 : mag2)};
        b_d     = op[2] ? mag2 : mag1;
      end
    end

    // kill beats everything but rst: no done, result untouched.
    if (kill) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      s1_q     <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      s1_q     <= s1_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed-vector bench for muldiv_unit with DATA_WIDTH=32, STEP=1.
//   Expected results are hand-computed constants pushed to exp_q and popped
//   when done is seen; latency and busy-cycle counts are checked per op.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int W    = 32;
  localparam int NLAT = 33;  // normal latency: 32 BUSY cycles + 1
  localparam int FLAT = 1;   // fast-path latency

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         kill;
  logic [2:0]   op;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp = '0;

  // clock / reset
  always #5 clk = ~clk;

  muldiv_unit #(.DATA_WIDTH(W), .STEP(1)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .in1    (in1),
    .in2    (in2),
    .kill   (kill),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge. Issues one op, scrambles the inputs after accept,
  // waits (bounded) for done and checks result, latency and busy cycles.
  // Returns at the negedge where done was observed high.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input int exp_lat);
    int           cyc;
    int           busy_cyc;
    logic         seen;
    logic [W-1:0] e;
    exp_q.push_back(exp);
    start = 1'b1;
    op    = o;
    in1   = a;
    in2   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'($urandom_range(0, 7));
    in1   = $urandom;
    in2   = $urandom;
    cyc      = 0;
    busy_cyc = 0;
    seen     = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cyc++;
      if (done) seen = 1'b1;
    end
    e = exp_q.pop_front();
    check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    check_eq({tag, "_result"}, result, e);
    check_eq({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check_eq({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_lat - 1));
    last_exp = e;
  endtask

  // One idle cycle after a done: done must have dropped.
  task automatic idle_gap(input string tag);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
    check_eq({tag, "_ready_idle"}, 32'(ready), 32'd1);
  endtask

  initial begin
    int done_cnt;
    rst   = 1'b1;
    start = 1'b0;
    kill  = 1'b0;
    op    = '0;
    in1   = '0;
    in2   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready",  32'(ready), 32'd1);
    check_eq("rst_busy",   32'(busy),  32'd0);
    check_eq("rst_done",   32'(done),  32'd0);
    check_eq("rst_result", result,     32'h0);

    // multiply
    run_op("mul",    OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, NLAT); idle_gap("mul");
    run_op("mulh",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, NLAT); idle_gap("mulh");
    run_op("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, NLAT); idle_gap("mulhu");
    run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NLAT); idle_gap("mulhsu");
    run_op("mul_nn", OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, NLAT); idle_gap("mul_nn");

    // divide
    run_op("div_neg",  OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, NLAT); idle_gap("div_neg");
    run_op("rem_neg",  OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, NLAT); idle_gap("rem_neg");
    run_op("div_negd", OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, NLAT); idle_gap("div_negd");
    run_op("rem_negd", OP_REM,  32'd7,         32'hFFFF_FFFE, 32'h0000_0001, NLAT); idle_gap("rem_negd");
    run_op("divu",     OP_DIVU, 32'd100,       32'd7,         32'd14,        NLAT); idle_gap("divu");
    run_op("remu",     OP_REMU, 32'd100,       32'd7,         32'd2,         NLAT); idle_gap("remu");

    // fast path
    run_op("divu_z",  OP_DIVU, 32'd100,       32'd0,         32'hFFFF_FFFF, FLAT); idle_gap("divu_z");
    run_op("remu_z",  OP_REMU, 32'd100,       32'd0,         32'd100,       FLAT); idle_gap("remu_z");
    run_op("rem_z",   OP_REM,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, FLAT); idle_gap("rem_z");
    run_op("div_ovf", OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, FLAT); idle_gap("div_ovf");
    run_op("rem_ovf", OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, FLAT); idle_gap("rem_ovf");

    // start together with kill must be ignored
    start = 1'b1; kill = 1'b1; op = OP_DIVU; in1 = 32'd50; in2 = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0; kill = 1'b0;
    @(negedge clk);
    check_eq("startkill_busy", 32'(busy), 32'd0);
    check_eq("startkill_done", 32'(done), 32'd0);

    // kill on BUSY cycle 10
    start = 1'b1; op = OP_DIVU; in1 = 32'd1000; in2 = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("kill_pre_busy", 32'(busy), 32'd1);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    @(negedge clk);
    check_eq("kill_busy",   32'(busy),  32'd0);
    check_eq("kill_ready",  32'(ready), 32'd1);
    check_eq("kill_done",   32'(done),  32'd0);
    check_eq("kill_result", result,     last_exp);
    run_op("after_kill", OP_DIVU, 32'd9, 32'd3, 32'd3, NLAT);

    // back-to-back: second start issued in the DONE cycle of the first
    run_op("b2b_div", OP_DIVU, 32'd100, 32'd7, 32'd14, NLAT);
    run_op("b2b_rem", OP_REMU, 32'd100, 32'd7, 32'd2,  NLAT);
    idle_gap("b2b");

    // reset mid-BUSY
    start = 1'b1; op = OP_MUL; in1 = 32'd3; in2 = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_result", result,     32'h0);
    check_eq("midrst_ready",  32'(ready), 32'd1);
    check_eq("midrst_busy",   32'(busy),  32'd0);
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check_eq("midrst_no_done", 32'(done_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
